weight_line_fetch: RTL and testbench

- Share-master stage that feeds the weight buffer.
- Fetches weight lines from external memory over an Avalon-MM burst read master.
- Packs each LINE_W/DATA_W-beat burst into one LINE_W-bit line.
- Presents each line with a one-cycle valid strobe on the line/valid pair that the weight buffer captures. One fetch command moves LineCnt_i consecutive lines starting at BaseAddr_i.

---
 rtl/weight_line_fetch.sv | 131 +++++++++++++
 tb/tb_weight_line_fetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_line_fetch.sv
// Weight line fetcher: reads LINE_W-bit lines from Avalon-MM as BEATS-beat bursts,
// packs each burst into one line and strobes it toward the weight buffer.
module weight_line_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LINE_W = 512,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Start_i,
    input  logic [ADDR_W-1:0]               BaseAddr_i,
    input  logic [CNT_W-1:0]                LineCnt_i,
    output logic                            Busy_o,
    output logic                            Done_o,
    output logic [ADDR_W-1:0]               AvmAddress_o,
    output logic                            AvmRead_o,
    output logic [$clog2(LINE_W/DATA_W):0]  AvmBurstCount_o,
    input  logic                            AvmWaitRequest_i,
    input  logic [DATA_W-1:0]               AvmReadData_i,
    input  logic                            AvmReadDataValid_i,
    output logic [LINE_W-1:0]               ShareMstLine_o,
    output logic                            ShareMstValid_o
);

    localparam int BEATS = LINE_W / DATA_W;
    localparam int BC_W  = $clog2(BEATS) + 1;
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(LINE_BYTES - ADDR_W'(1));
    localparam logic [K_W-1:0]    LAST_BEAT  = K_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        DONE
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [ADDR_W-1:0]              line_addr;
    logic [CNT_W-1:0]               lines_left;
    logic [K_W-1:0]                 beat_idx;
    logic [BEATS-1:0][DATA_W-1:0]   line_buf;
    logic [BEATS-1:0][DATA_W-1:0]   line_assembled;
    logic                           beat_fire;
    logic                           last_beat;

    assign beat_fire = (state == RECV) && AvmReadDataValid_i;
    assign last_beat = beat_fire && (beat_idx == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        Busy_o          = (state != IDLE);
        Done_o          = 1'b0;
        AvmRead_o       = 1'b0;
        AvmAddress_o    = '0;
        AvmBurstCount_o = '0;
        case (state)
            IDLE: begin
                if (Start_i) begin
                    state_next = (LineCnt_i == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                AvmRead_o       = 1'b1;
                AvmAddress_o    = line_addr;
                AvmBurstCount_o = BC_W'(BEATS);
                if (!AvmWaitRequest_i) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (last_beat) begin
                    state_next = (lines_left == CNT_W'(1)) ? DONE : REQ;
                end
            end
            DONE: begin
                Done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The final beat goes straight into the emitted line rather than waiting a cycle in line_buf.
    always_comb begin
        line_assembled           = line_buf;
        line_assembled[beat_idx] = AvmReadData_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr       <= '0;
            lines_left      <= '0;
            beat_idx        <= '0;
            line_buf        <= '0;
            ShareMstLine_o  <= '0;
            ShareMstValid_o <= 1'b0;
        end else begin
            ShareMstValid_o <= 1'b0;
            if (state == IDLE && Start_i) begin
                line_addr  <= BaseAddr_i & ALIGN_MASK;
                lines_left <= LineCnt_i;
                beat_idx   <= '0;
            end
            if (beat_fire) begin
                line_buf[beat_idx] <= AvmReadData_i;
                if (last_beat) begin
                    ShareMstLine_o  <= line_assembled;
                    ShareMstValid_o <= 1'b1;
                    line_addr       <= line_addr + LINE_BYTES;
                    lines_left      <= lines_left - CNT_W'(1);
                    beat_idx        <= '0;
                end else begin
                    beat_idx <= beat_idx + K_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_line_fetch.sv
// Randomized bench for weight_line_fetch: an Avalon slave model feeds bursts while a
// queue-based reference predicts request addresses and assembled lines.
module tb_weight_line_fetch;

    typedef logic [511:0] wide_t;

    logic          clk;
    logic          rst;
    logic          Start_i;
    logic [31:0]   BaseAddr_i;
    logic [15:0]   LineCnt_i;
    logic          Busy_o;
    logic          Done_o;
    logic [31:0]   AvmAddress_o;
    logic          AvmRead_o;
    logic [3:0]    AvmBurstCount_o;
    logic          AvmWaitRequest_i;
    logic [63:0]   AvmReadData_i;
    logic          AvmReadDataValid_i;
    logic [511:0]  ShareMstLine_o;
    logic          ShareMstValid_o;

    weight_line_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .Start_i            (Start_i),
        .BaseAddr_i         (BaseAddr_i),
        .LineCnt_i          (LineCnt_i),
        .Busy_o             (Busy_o),
        .Done_o             (Done_o),
        .AvmAddress_o       (AvmAddress_o),
        .AvmRead_o          (AvmRead_o),
        .AvmBurstCount_o    (AvmBurstCount_o),
        .AvmWaitRequest_i   (AvmWaitRequest_i),
        .AvmReadData_i      (AvmReadData_i),
        .AvmReadDataValid_i (AvmReadDataValid_i),
        .ShareMstLine_o     (ShareMstLine_o),
        .ShareMstValid_o    (ShareMstValid_o)
    );

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [31:0]  exp_addr_q[$];
    wide_t        exp_line_q[$];
    logic [63:0]  beat_q[$];
    bit           accept_pending = 0;
    int           stall_cfg = 0;
    int           gap_mode = 0;
    int           beat_pat = 0;
    int           beats_driven = 0;
    int           done_cnt = 0;
    int           strobe_cnt = 0;
    int           req_cnt = 0;
    int           cur_cnt = 0;
    wide_t        last_line = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Slave model: stalls each new request, then returns a burst of beats with optional gaps.
    initial begin
        bit          req_seen;
        int          stall_left;
        int          gap_ctr;
        bit          take;
        wide_t       line;
        logic [63:0] beat;
        req_seen = 0;
        stall_left = 0;
        gap_ctr = 0;
        AvmWaitRequest_i = 1'b0;
        AvmReadDataValid_i = 1'b0;
        AvmReadData_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (accept_pending) begin
                accept_pending = 0;
                line = '0;
                for (int k = 0; k < 8; k++) begin
                    beat = (beat_pat == 1) ? 64'h1111_1111_1111_1111 * 64'(k) : {$urandom, $urandom};
                    beat_q.push_back(beat);
                    line[k*64 +: 64] = beat;
                end
                exp_line_q.push_back(line);
            end
            if (AvmRead_o) begin
                if (!req_seen) begin
                    req_seen = 1;
                    stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
                end
                if (stall_left > 0) begin
                    AvmWaitRequest_i = 1'b1;
                    stall_left--;
                end else begin
                    AvmWaitRequest_i = 1'b0;
                end
            end else begin
                req_seen = 0;
                AvmWaitRequest_i = 1'($urandom_range(0, 1));
            end
            if (beat_q.size() > 0) begin
                case (gap_mode)
                    0:       take = 1;
                    1:       take = (gap_ctr % 3 == 0);
                    default: take = 1'($urandom_range(0, 1));
                endcase
                gap_ctr++;
                if (take) begin
                    AvmReadDataValid_i = 1'b1;
                    AvmReadData_i = beat_q.pop_front();
                    beats_driven++;
                end else begin
                    AvmReadDataValid_i = 1'b0;
                    AvmReadData_i = {$urandom, $urandom};
                end
            end else begin
                gap_ctr = 0;
                AvmReadDataValid_i = ($urandom_range(0, 3) == 0);
                AvmReadData_i = {$urandom, $urandom};
            end
        end
    end

    // Monitor: line strobes are handled before request acceptance because both can share a cycle.
    initial begin
        bit          prev_read;
        bit          prev_wait;
        logic [31:0] prev_addr;
        wide_t       exp_line;
        prev_read = 0;
        prev_wait = 0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (ShareMstValid_o) begin
                strobe_cnt++;
                checkOutput("strobe_expected", wide_t'(exp_line_q.size() != 0), wide_t'(1));
                if (exp_line_q.size() != 0) begin
                    exp_line = exp_line_q.pop_front();
                    last_line = exp_line;
                    checkOutput("line_data", ShareMstLine_o, exp_line);
                    checkOutput("done_on_last", wide_t'(Done_o),
                                wide_t'(exp_line_q.size() == 0 && exp_addr_q.size() == 0));
                end
            end
            if (Done_o) begin
                done_cnt++;
                checkOutput("done_busy", wide_t'(Busy_o), wide_t'(1));
                checkOutput("done_with_last_strobe", wide_t'(ShareMstValid_o), wide_t'(cur_cnt != 0));
            end
            if (prev_read && prev_wait) begin
                checkOutput("read_held", wide_t'(AvmRead_o), wide_t'(1));
                checkOutput("addr_stable", wide_t'(AvmAddress_o), wide_t'(prev_addr));
            end
            if (AvmRead_o) begin
                checkOutput("burstcount", wide_t'(AvmBurstCount_o), wide_t'(8));
                if (!AvmWaitRequest_i) begin
                    req_cnt++;
                    checkOutput("req_expected", wide_t'(exp_addr_q.size() != 0), wide_t'(1));
                    if (exp_addr_q.size() != 0) begin
                        checkOutput("req_addr", wide_t'(AvmAddress_o), wide_t'(exp_addr_q.pop_front()));
                    end
                    accept_pending = 1;
                end
            end
            prev_read = AvmRead_o;
            prev_wait = AvmWaitRequest_i;
            prev_addr = AvmAddress_o;
        end
    end

    task automatic startFetch(input logic [31:0] base, input int cnt);
        logic [31:0] addr;
        exp_addr_q.delete();
        addr = base - (base % 32'd64);
        for (int i = 0; i < cnt; i++) begin
            exp_addr_q.push_back(addr);
            addr = addr + 32'd64;
        end
        cur_cnt = cnt;
        done_cnt = 0;
        strobe_cnt = 0;
        req_cnt = 0;
        beats_driven = 0;
        @(posedge clk);
        #1;
        Start_i = 1'b1;
        BaseAddr_i = base;
        LineCnt_i = 16'(cnt);
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        checkOutput("busy_after_start", wide_t'(Busy_o), wide_t'(1));
    endtask

    task automatic applyStimulus(input logic [31:0] base, input int cnt, input int stall,
                                 input int gap, input int pat, input bit mid_start);
        int cyc;
        stall_cfg = stall;
        gap_mode = gap;
        beat_pat = pat;
        startFetch(base, cnt);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            if (mid_start && cyc == 8) begin
                Start_i = 1'b1;
                BaseAddr_i = 32'h0000_9000;
                LineCnt_i = 16'd5;
            end else begin
                Start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        Start_i = 1'b0;
        checkOutput("done_seen", wide_t'(done_cnt), wide_t'(1));
        checkOutput("busy_after_done", wide_t'(Busy_o), wide_t'(0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", wide_t'(done_cnt), wide_t'(1));
        checkOutput("strobe_count", wide_t'(strobe_cnt), wide_t'(cnt));
        checkOutput("req_count", wide_t'(req_cnt), wide_t'(cnt));
        if (cnt != 0) begin
            checkOutput("line_hold", ShareMstLine_o, last_line);
        end
    endtask

    task automatic resetMidBurst();
        int cyc;
        stall_cfg = 0;
        gap_mode = 0;
        beat_pat = 0;
        startFetch(32'h0000_4000, 3);
        cyc = 0;
        while (beats_driven < 12 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("reach_line2_beat3", wide_t'(beats_driven >= 12), wide_t'(1));
        #2;
        rst = 1'b1;
        exp_addr_q.delete();
        exp_line_q.delete();
        accept_pending = 0;
        #1;
        checkOutput("rst_busy", wide_t'(Busy_o), wide_t'(0));
        checkOutput("rst_done", wide_t'(Done_o), wide_t'(0));
        checkOutput("rst_read", wide_t'(AvmRead_o), wide_t'(0));
        checkOutput("rst_addr", wide_t'(AvmAddress_o), wide_t'(0));
        checkOutput("rst_burstcount", wide_t'(AvmBurstCount_o), wide_t'(0));
        checkOutput("rst_valid", wide_t'(ShareMstValid_o), wide_t'(0));
        checkOutput("rst_line", ShareMstLine_o, wide_t'(0));
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        cyc = 0;
        while (beat_q.size() > 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_strobe_after_reset", wide_t'(strobe_cnt), wide_t'(1));
        checkOutput("no_done_after_reset", wide_t'(done_cnt), wide_t'(0));
        checkOutput("idle_after_reset", wide_t'(Busy_o), wide_t'(0));
    endtask

    initial begin
        rst = 1'b1;
        Start_i = 1'b0;
        BaseAddr_i = '0;
        LineCnt_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", wide_t'(Busy_o), wide_t'(0));
        checkOutput("reset_done", wide_t'(Done_o), wide_t'(0));
        checkOutput("reset_read", wide_t'(AvmRead_o), wide_t'(0));
        checkOutput("reset_valid", wide_t'(ShareMstValid_o), wide_t'(0));
        checkOutput("reset_line", ShareMstLine_o, wide_t'(0));
        rst = 1'b0;

        applyStimulus(32'h0000_1000, 1, 0, 0, 1, 0);
        applyStimulus(32'h0000_2000, 3, 2, 0, 0, 0);
        applyStimulus(32'h0000_5000, 1, 0, 1, 0, 0);
        applyStimulus(32'h0000_6000, 0, 0, 0, 0, 0);
        applyStimulus(32'h0000_7000, 3, 1, 2, 0, 1);
        applyStimulus(32'h0000_3013, 1, 0, 0, 0, 0);
        applyStimulus(32'hFFFF_FFC5, 2, 1, 2, 0, 0);
        for (int n = 0; n < 6; n++) begin
            applyStimulus($urandom, int'($urandom_range(1, 4)), -1, 2, 0, 0);
        end
        resetMidBurst();
        applyStimulus(32'h0000_8000, 2, -1, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
